run_length_detector: RTL

//  Multi-channel, parametrised successor to the single-channel "four consecutive 1s" detector.

---
 rtl/rld_pkg.sv | 16 +
 rtl/rld_channel.sv | 83 ++++++++
 rtl/run_length_detector.sv | 49 ++++
 3 files changed

// File: rtl/rld_pkg.sv
// Shared constants and helpers for the run-length detector.
// Optional statistics are enabled by defining RLD_STATS_EN.
package rld_pkg;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_PULSE = 1'b1;

    localparam int DEF_CNT_W  = 4;
    localparam int DEF_STAT_W = 16;

    // Saturating increment; callers zero-extend into 32 bits and truncate the result.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/rld_channel.sv
// One channel of the run-length detector: run counter, detect flag and,
// with RLD_STATS_EN defined, a saturating hit counter.
module rld_channel
    import rld_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int STAT_W = DEF_STAT_W
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              en,
    input  logic              w,
    input  logic              target,
    input  logic              mode,
    input  logic [CNT_W-1:0]  thresh,
`ifdef RLD_STATS_EN
    input  logic              clr_stat,
    output logic [STAT_W-1:0] hit_cnt,
`endif
    output logic              z
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W:0]   cnt_plus;
    logic [CNT_W-1:0] cnt_nxt;
    logic             m;
    logic             z_nxt;
    logic             hit;

    assign m        = (w == target);
    assign cnt_inc  = CNT_W'(sat_inc(32'(cnt), 32'({CNT_W{1'b1}})));
    assign cnt_plus = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};

    // thresh arrives already mapped so that it is never zero.
    always_comb begin
        cnt_nxt = cnt;
        z_nxt   = z;
        if (!m) begin
            cnt_nxt = '0;
            z_nxt   = 1'b0;
        end else if (mode == MODE_LEVEL) begin
            cnt_nxt = cnt_inc;
            z_nxt   = (cnt_inc >= thresh);
        end else if (cnt_plus >= {1'b0, thresh}) begin
            cnt_nxt = '0;
            z_nxt   = 1'b1;
        end else begin
            cnt_nxt = cnt_plus[CNT_W-1:0];
            z_nxt   = 1'b0;
        end
    end

    // A LEVEL hit is only the rising edge of z; a PULSE hit is every pulse.
    assign hit = (mode == MODE_PULSE) ? z_nxt : (z_nxt & ~z);

    always_ff @(posedge clock) begin
        if (!rst) begin
            cnt <= '0;
            z   <= 1'b0;
        end else if (en) begin
            cnt <= cnt_nxt;
            z   <= z_nxt;
        end
    end

`ifdef RLD_STATS_EN
    always_ff @(posedge clock) begin
        if (!rst) begin
            hit_cnt <= '0;
        end else if (en) begin
            if (clr_stat)
                hit_cnt <= '0;
            else if (hit)
                hit_cnt <= STAT_W'(sat_inc(32'(hit_cnt), 32'({STAT_W{1'b1}})));
        end
    end
`else
    logic unused_hit;
    assign unused_hit = hit;
`endif

endmodule

// File: rtl/run_length_detector.sv
// Multi-channel programmable run-length detector; per-channel hit
// statistics are present only when RLD_STATS_EN is defined.
module run_length_detector
    import rld_pkg::*;
#(
    parameter int CH     = 4,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int STAT_W = DEF_STAT_W
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 en,
    input  logic [CH-1:0]        w,
    input  logic                 target,
    input  logic                 mode,
    input  logic [CNT_W-1:0]     thresh,
`ifdef RLD_STATS_EN
    input  logic                 clr_stat,
    output logic [CH*STAT_W-1:0] hit_cnt,
`endif
    output logic [CH-1:0]        z
);

    logic [CNT_W-1:0] t_eff;

    // A zero threshold behaves as a run length of one.
    assign t_eff = (thresh == '0) ? CNT_W'(1) : thresh;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        rld_channel #(
            .CNT_W  (CNT_W),
            .STAT_W (STAT_W)
        ) u_ch (
            .clock    (clock),
            .rst      (rst),
            .en       (en),
            .w        (w[i]),
            .target   (target),
            .mode     (mode),
            .thresh   (t_eff),
`ifdef RLD_STATS_EN
            .clr_stat (clr_stat),
            .hit_cnt  (hit_cnt[i*STAT_W +: STAT_W]),
`endif
            .z        (z[i])
        );
    end

endmodule
